rc_nrzi: RTL

Receive-path stage directly downstream of the D+/D- line decoder. It takes the per-cycle line level (J=1, K=0) between the start and end strobes, NRZI-decodes it and removes stuffed bits. It delivers a clean decoded bit stream with valid strobes and packet framing to the packet shift/CRC stage. Detects bit-stuff violations.

---
 rtl/usb_rc_pkg.sv | 25 ++
 rtl/counter.sv | 31 +++
 rtl/rc_nrzi.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/usb_rc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_rc_pkg
// Purpose : Types and constants shared by the receive-path NRZI/destuff stage.
//           nrzi_state_t - receive FSM states
//           LVL_J/LVL_K  - line level encodings from the D+/D- decoder
//           MAX_RUN_DEFAULT - decoded 1s before a mandatory stuff bit
// Revision: 1.0 - initial release
// ============================================================================
package usb_rc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERROR = 2'd3
  } nrzi_state_t;

  localparam logic LVL_J = 1'b1;
  localparam logic LVL_K = 1'b0;

  localparam int MAX_RUN_DEFAULT = 6;

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module  : counter
// Purpose : Saturating up-counter with synchronous clear.
//           clr alone loads 0; clr together with en loads 1 (clear, then count
//           the current cycle); en alone increments, holding at all-ones.
// Ports   : clk, rst (sync, active-high), clr, en -> q[W-1:0]
// Revision: 1.0 - initial release
// ============================================================================
module counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= en ? W'(1) : '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rc_nrzi.sv
`default_nettype none
// ============================================================================
// Module  : rc_nrzi
// Purpose : NRZI decode and bit-destuffing of the received line level, with
//           packet framing and stuff-violation detection.
// Ports   : clk, rst          - clock / sync active-high reset
//           s_in              - line level (1=J, 0=K), data between strobes
//           start_rc_nrzi     - pulse on final SYNC K (not data)
//           end_rc_nrzi       - pulse on first SE0 / bit-count end (not data)
//           abort             - synchronous flush, same as rst
//           bit_out/bit_valid - decoded bit stream, 1-cycle latency
//           pkt_start/pkt_end - framing pulses
//           stuff_error       - sticky stuff violation flag
//           bit_cnt           - data bits delivered this packet (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module rc_nrzi
  import usb_rc_pkg::*;
#(
  parameter int MAX_RUN = MAX_RUN_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             start_rc_nrzi,
  input  logic             end_rc_nrzi,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             pkt_start,
  output logic             pkt_end,
  output logic             stuff_error,
  output logic [CNT_W-1:0] bit_cnt
);

  nrzi_state_t state_q, state_d;

  logic       flush;
  logic       prev_lvl, prev_lvl_d;
  logic       dec;
  logic       emit;
  logic       pkt_start_d, pkt_end_d, stuff_error_d;
  logic       run_clr, run_en;
  logic       cnt_clr;
  logic [2:0] run;

  assign flush = rst | abort;
  assign dec   = ~(s_in ^ prev_lvl);

  counter #(.W(3)) u_run_cnt (
    .clk (clk),
    .rst (flush),
    .clr (run_clr),
    .en  (run_en),
    .q   (run)
  );

  counter #(.W(CNT_W)) u_bit_cnt (
    .clk (clk),
    .rst (flush),
    .clr (cnt_clr),
    .en  (emit),
    .q   (bit_cnt)
  );

  always_comb begin
    state_d       = state_q;
    prev_lvl_d    = prev_lvl;
    emit          = 1'b0;
    pkt_start_d   = 1'b0;
    pkt_end_d     = 1'b0;
    stuff_error_d = stuff_error;
    run_clr       = 1'b0;
    run_en        = 1'b0;
    cnt_clr       = 1'b0;

    if (start_rc_nrzi) begin
      // Start wins over end and restarts from any state. The trailing 1 of
      // SYNC counts toward the first run, hence clear+count -> run = 1.
      state_d       = RUN;
      prev_lvl_d    = LVL_K;
      run_clr       = 1'b1;
      run_en        = 1'b1;
      cnt_clr       = 1'b1;
      pkt_start_d   = 1'b1;
      stuff_error_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (end_rc_nrzi) begin
            pkt_end_d = 1'b1;
            state_d   = IDLE;
          end else begin
            prev_lvl_d = s_in;
            emit       = 1'b1;
            if (dec) begin
              run_en = 1'b1;
              if (run == 3'(MAX_RUN - 1)) state_d = STUFF;
            end else begin
              run_clr = 1'b1;
            end
          end
        end
        STUFF: begin
          if (end_rc_nrzi) begin
            // Packet ended where a stuff bit was owed.
            stuff_error_d = 1'b1;
            state_d       = ERROR;
          end else begin
            prev_lvl_d = s_in;
            if (!dec) begin
              run_clr = 1'b1;
              state_d = RUN;
            end else begin
              stuff_error_d = 1'b1;
              state_d       = ERROR;
            end
          end
        end
        default: ;  // IDLE and ERROR wait for start_rc_nrzi
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q     <= IDLE;
      prev_lvl    <= LVL_K;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      pkt_start   <= 1'b0;
      pkt_end     <= 1'b0;
      stuff_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_lvl    <= prev_lvl_d;
      bit_out     <= emit & dec;
      bit_valid   <= emit;
      pkt_start   <= pkt_start_d;
      pkt_end     <= pkt_end_d;
      stuff_error <= stuff_error_d;
    end
  end

endmodule
`default_nettype wire
